// File: rtl/sockit_spi_pkg.sv
// Shared types for the SPI XIP read engine: command control word layout, IO mode/direction codes, FSM encoding.
package sockit_spi_pkg;

    typedef enum logic [1:0] {
        IOM_SGL = 2'd0,
        IOM_DUA = 2'd1,
        IOM_QUA = 2'd2
    } iom_e;

    typedef enum logic [1:0] {
        DIR_DMY = 2'd0,
        DIR_WR  = 2'd1,
        DIR_RD  = 2'd2
    } dir_e;

    typedef struct packed {
        logic       sse;
        iom_e       iom;
        dir_e       dir;
        logic [6:0] len;
    } cmo_ctl_t;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDL = 3'd0;
    localparam state_t ST_OPC = 3'd1;
    localparam state_t ST_ADR = 3'd2;
    localparam state_t ST_DMY = 3'd3;
    localparam state_t ST_DAT = 3'd4;
    localparam state_t ST_WAI = 3'd5;
    localparam state_t ST_RSP = 3'd6;

    // Mode 3 is reserved and runs as quad.
    function automatic iom_e iom_map(input logic [1:0] m);
        return (m == 2'd3) ? IOM_QUA : iom_e'(m);
    endfunction

endpackage

// File: rtl/sockit_spi_xip_buf.sv
// One-line prefetch buffer: BRS x 32-bit words plus line tag and valid bit.
// Write port registered, read port combinational; clear wins over set on valid.
module sockit_spi_xip_buf
    import sockit_spi_pkg::*;
#(
    parameter int BRS = 4,
    parameter int TGW = 20,
    parameter int CNW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [CNW-1:0]  wr_idx,
    input  logic [31:0]     wr_dat,
    input  logic [CNW-1:0]  rd_idx,
    output logic [31:0]     rd_dat,
    input  logic            tag_wen,
    input  logic [TGW-1:0]  tag_wdt,
    output logic [TGW-1:0]  tag,
    input  logic            vld_set,
    input  logic            vld_clr,
    output logic            vld
);

    logic [31:0] mem [BRS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_dat;
        end
        if (tag_wen) begin
            tag <= tag_wdt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= 1'b0;
        end else if (vld_clr) begin
            vld <= 1'b0;
        end else if (vld_set) begin
            vld <= 1'b1;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/sockit_spi_xip_line.sv
// XIP read engine: bus misses become flash fast-read command streams that fill a one-line buffer; hits return in zero wait cycles.
// Miss: response one cycle after the last cmi beat; cmo beats held stable until cmo_rdy; wrq asserted while a fill is in flight.
module sockit_spi_xip_line
    import sockit_spi_pkg::*;
#(
    parameter logic [31:0] NOP = 32'h0000_0000,
    parameter int          XAW = 24,
    parameter int          ADW = 24,
    parameter int          BRS = 4,
    parameter int          CCO = 12,
    parameter int          CCI = 4,
    parameter int          CDW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            xip_wen,
    input  logic            xip_ren,
    input  logic [XAW-1:0]  xip_adr,
    input  logic [3:0]      xip_ben,
    input  logic [31:0]     xip_wdt,
    output logic [31:0]     xip_rdt,
    output logic            xip_wrq,
    output logic            xip_err,
    input  logic [7:0]      cfg_cmd,
    input  logic [1:0]      cfg_iom,
    input  logic [3:0]      cfg_dmy,
    input  logic            cfg_inv,
    input  logic [31:0]     adr_rof,
    output logic            cmo_vld,
    output logic [CCO-1:0]  cmo_ctl,
    output logic [CDW-1:0]  cmo_dat,
    input  logic            cmo_rdy,
    input  logic            cmi_vld,
    input  logic [CCI-1:0]  cmi_ctl,
    input  logic [CDW-1:0]  cmi_dat,
    output logic            cmi_rdy
);

    localparam int LNW = $clog2(BRS) + 2;
    localparam int TGW = ADW - LNW;
    localparam int CNW = (BRS > 1) ? $clog2(BRS) : 1;
    localparam logic [CNW-1:0] LAST = CNW'(BRS - 1);

    state_t         state, state_nxt;
    logic [CNW-1:0] cmo_cnt, cmi_cnt, lat_idx;
    logic [7:0]     lat_cmd;
    iom_e           lat_iom;
    logic [3:0]     lat_dmy;
    logic           lat_err, lat_inv;

    logic [ADW-1:0] fad;
    logic [TGW-1:0] cur_tag, buf_tag;
    logic [CNW-1:0] cur_idx, rd_idx;
    logic [31:0]    rd_dat, cmi_swp;
    logic           buf_vld, hit, cmi_hs, cmi_last, err_nxt;
    logic           miss_start, fill_done, vld_set, vld_clr;
    cmo_ctl_t       ctl;
    logic           unused_sig;

    assign fad     = ADW'(xip_adr) + adr_rof[ADW-1:0];
    assign cur_tag = fad[ADW-1:LNW];
    assign cur_idx = CNW'(fad[ADW-1:2]) & LAST;
    assign hit     = buf_vld & ~cfg_inv & (buf_tag == cur_tag);

    assign cmi_rdy  = ~rst & ((state == ST_DAT) | (state == ST_WAI));
    assign cmi_hs   = cmi_vld & cmi_rdy;
    assign cmi_last = cmi_hs & (cmi_cnt == LAST);
    assign err_nxt  = lat_err | (cmi_hs & cmi_ctl[0]);
    // First flash byte lands in the least significant byte lane.
    assign cmi_swp  = {cmi_dat[7:0], cmi_dat[15:8], cmi_dat[23:16], cmi_dat[31:24]};
    assign rd_idx   = (state == ST_RSP) ? lat_idx : cur_idx;

    assign vld_set = fill_done & ~err_nxt & ~lat_inv & ~cfg_inv;
    assign vld_clr = miss_start | cfg_inv;

    assign unused_sig = ^{xip_ben, xip_wdt, cmi_ctl, cmi_dat, adr_rof, fad[1:0]};

    always_comb begin
        state_nxt  = state;
        miss_start = 1'b0;
        fill_done  = 1'b0;
        xip_wrq    = 1'b0;
        xip_err    = 1'b0;
        xip_rdt    = NOP;
        cmo_vld    = 1'b0;
        ctl        = '0;
        cmo_dat    = '0;
        case (state)
            ST_IDL: begin
                if (xip_wen) begin
                    xip_err = 1'b1;
                end else if (xip_ren) begin
                    if (hit) begin
                        xip_rdt = rd_dat;
                    end else begin
                        xip_wrq    = 1'b1;
                        miss_start = 1'b1;
                        state_nxt  = ST_OPC;
                    end
                end
            end
            ST_OPC: begin
                cmo_vld  = 1'b1;
                ctl.iom  = IOM_SGL;
                ctl.dir  = DIR_WR;
                ctl.len  = 7'd7;
                cmo_dat  = {lat_cmd, {(CDW-8){1'b0}}};
                if (cmo_rdy) state_nxt = ST_ADR;
            end
            ST_ADR: begin
                cmo_vld  = 1'b1;
                ctl.iom  = lat_iom;
                ctl.dir  = DIR_WR;
                ctl.len  = 7'(ADW - 1);
                cmo_dat  = CDW'({buf_tag, {LNW{1'b0}}}) << (CDW - ADW);
                if (cmo_rdy) state_nxt = (lat_dmy != 4'd0) ? ST_DMY : ST_DAT;
            end
            ST_DMY: begin
                cmo_vld  = 1'b1;
                ctl.iom  = lat_iom;
                ctl.dir  = DIR_DMY;
                ctl.len  = {3'b000, lat_dmy - 4'd1};
                if (cmo_rdy) state_nxt = ST_DAT;
            end
            ST_DAT: begin
                cmo_vld  = 1'b1;
                ctl.sse  = (cmo_cnt == LAST);
                ctl.iom  = lat_iom;
                ctl.dir  = DIR_RD;
                ctl.len  = 7'd31;
                if (cmo_rdy && cmo_cnt == LAST) begin
                    fill_done = cmi_last;
                    state_nxt = cmi_last ? ST_RSP : ST_WAI;
                end
            end
            ST_WAI: begin
                if (cmi_last) begin
                    fill_done = 1'b1;
                    state_nxt = ST_RSP;
                end
            end
            ST_RSP: begin
                state_nxt = ST_IDL;
                if (lat_err) xip_err = 1'b1;
                else         xip_rdt = rd_dat;
            end
            default: state_nxt = ST_IDL;
        endcase
        if (state != ST_IDL && state != ST_RSP) begin
            xip_wrq = xip_ren | xip_wen;
        end
        if (rst) begin
            state_nxt  = ST_IDL;
            miss_start = 1'b0;
            fill_done  = 1'b0;
            xip_wrq    = xip_ren | xip_wen;
            xip_err    = 1'b0;
            xip_rdt    = NOP;
            cmo_vld    = 1'b0;
        end
    end

    assign cmo_ctl = CCO'(ctl);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDL;
            cmo_cnt <= '0;
            cmi_cnt <= '0;
            lat_idx <= '0;
            lat_cmd <= '0;
            lat_iom <= IOM_SGL;
            lat_dmy <= '0;
            lat_err <= 1'b0;
            lat_inv <= 1'b0;
        end else begin
            state <= state_nxt;
            if (miss_start) begin
                lat_idx <= cur_idx;
                lat_cmd <= cfg_cmd;
                lat_iom <= iom_map(cfg_iom);
                lat_dmy <= cfg_dmy;
                cmo_cnt <= '0;
                cmi_cnt <= '0;
                lat_err <= 1'b0;
                lat_inv <= 1'b0;
            end else begin
                if (state == ST_DAT && cmo_rdy) cmo_cnt <= cmo_cnt + 1'b1;
                if (cmi_hs) begin
                    cmi_cnt <= cmi_cnt + 1'b1;
                    lat_err <= err_nxt;
                end
                if (cfg_inv && state != ST_IDL) lat_inv <= 1'b1;
            end
        end
    end

    sockit_spi_xip_buf #(
        .BRS (BRS),
        .TGW (TGW),
        .CNW (CNW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cmi_hs),
        .wr_idx  (cmi_cnt),
        .wr_dat  (cmi_swp),
        .rd_idx  (rd_idx),
        .rd_dat  (rd_dat),
        .tag_wen (miss_start),
        .tag_wdt (cur_tag),
        .tag     (buf_tag),
        .vld_set (vld_set),
        .vld_clr (vld_clr),
        .vld     (buf_vld)
    );

endmodule

// File: tb/tb_sockit_spi_xip_line.sv
// Directed bench for sockit_spi_xip_line: a 24-bit-address instance plus a 32-bit-address twin sharing all inputs.
module tb_sockit_spi_xip_line;

    logic        clk = 1'b0;
    logic        rst;
    logic        xip_wen, xip_ren;
    logic [23:0] xip_adr;
    logic [3:0]  xip_ben;
    logic [31:0] xip_wdt;
    logic [31:0] xip_rdt, xip_rdt32;
    logic        xip_wrq, xip_wrq32, xip_err, xip_err32;
    logic [7:0]  cfg_cmd;
    logic [1:0]  cfg_iom;
    logic [3:0]  cfg_dmy;
    logic        cfg_inv;
    logic [31:0] adr_rof;
    logic        cmo_vld, cmo_vld32, cmo_rdy;
    logic [11:0] cmo_ctl, cmo_ctl32;
    logic [31:0] cmo_dat, cmo_dat32;
    logic        cmi_vld, cmi_rdy, cmi_rdy32;
    logic [3:0]  cmi_ctl;
    logic [31:0] cmi_dat;

    int n_vec = 0;
    int n_err = 0;

    logic [43:0] lg[$];
    logic [43:0] lg32[$];
    logic [31:0] words [4];
    int          err_beat = -1;

    always #5 clk = ~clk;

    sockit_spi_xip_line dut (
        .clk(clk), .rst(rst), .xip_wen(xip_wen), .xip_ren(xip_ren), .xip_adr(xip_adr),
        .xip_ben(xip_ben), .xip_wdt(xip_wdt), .xip_rdt(xip_rdt), .xip_wrq(xip_wrq), .xip_err(xip_err),
        .cfg_cmd(cfg_cmd), .cfg_iom(cfg_iom), .cfg_dmy(cfg_dmy), .cfg_inv(cfg_inv), .adr_rof(adr_rof),
        .cmo_vld(cmo_vld), .cmo_ctl(cmo_ctl), .cmo_dat(cmo_dat), .cmo_rdy(cmo_rdy),
        .cmi_vld(cmi_vld), .cmi_ctl(cmi_ctl), .cmi_dat(cmi_dat), .cmi_rdy(cmi_rdy)
    );

    sockit_spi_xip_line #(.ADW(32)) dut32 (
        .clk(clk), .rst(rst), .xip_wen(xip_wen), .xip_ren(xip_ren), .xip_adr(xip_adr),
        .xip_ben(xip_ben), .xip_wdt(xip_wdt), .xip_rdt(xip_rdt32), .xip_wrq(xip_wrq32), .xip_err(xip_err32),
        .cfg_cmd(cfg_cmd), .cfg_iom(cfg_iom), .cfg_dmy(cfg_dmy), .cfg_inv(cfg_inv), .adr_rof(adr_rof),
        .cmo_vld(cmo_vld32), .cmo_ctl(cmo_ctl32), .cmo_dat(cmo_dat32), .cmo_rdy(cmo_rdy),
        .cmi_vld(cmi_vld), .cmi_ctl(cmi_ctl), .cmi_dat(cmi_dat), .cmi_rdy(cmi_rdy32)
    );

    task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    // Flash model: answers each accepted read beat with one cmi word on the following cycle.
    initial begin
        bit rd_hs, ci_hs;
        int pend = 0;
        int k = 0;
        cmi_vld = 1'b0;
        cmi_dat = '0;
        cmi_ctl = '0;
        forever begin
            @(negedge clk);
            rd_hs = cmo_vld && cmo_rdy && (cmo_ctl[8:7] == 2'd2);
            ci_hs = cmi_vld && cmi_rdy;
            if (cmo_vld && cmo_rdy) lg.push_back({cmo_ctl, cmo_dat});
            if (cmo_vld32 && cmo_rdy) lg32.push_back({cmo_ctl32, cmo_dat32});
            @(posedge clk);
            #2;
            if (rst) begin
                pend = 0;
                k = 0;
            end else begin
                if (ci_hs) begin
                    k = (k + 1) % 4;
                    pend--;
                end
                if (rd_hs) pend++;
            end
            cmi_vld = (pend > 0);
            cmi_dat = words[k];
            cmi_ctl = {3'b000, (k == err_beat)};
        end
    end

    task automatic wait_rsp(output logic [31:0] rdt, output logic err, output int waits);
        bit done = 0;
        waits = 0;
        rdt = 'x;
        err = 'x;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!xip_wrq) begin
                rdt  = xip_rdt;
                err  = xip_err;
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk);
            #1;
        end
        if (!done) check_vec("rsp_timeout", 64'd0, 64'd1);
        xip_ren = 1'b0;
    endtask

    task automatic bus_read(input logic [23:0] a, output logic [31:0] rdt, output logic err, output int waits);
        xip_ren = 1'b1;
        xip_adr = a;
        wait_rsp(rdt, err, waits);
    endtask

    initial begin
        logic [31:0] rdt;
        logic        err;
        int          waits;
        bit          found;

        words[0] = 32'hA0A1A2A3;
        words[1] = 32'h00112233;
        words[2] = 32'hC0C1C2C3;
        words[3] = 32'hD0D1D2D3;
        rst = 1'b1; xip_wen = 1'b0; xip_ren = 1'b0; xip_adr = '0; xip_ben = 4'hF; xip_wdt = '0;
        cfg_cmd = 8'h6b; cfg_iom = 2'd2; cfg_dmy = 4'd8; cfg_inv = 1'b0; adr_rof = '0; cmo_rdy = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_vec("rst_cmo_vld", cmo_vld, 1'b0);
        check_vec("rst_cmi_rdy", cmi_rdy, 1'b0);
        check_vec("rst_err", xip_err, 1'b0);
        check_vec("rst_rdt", xip_rdt, 32'h0);
        check_vec("rst_wrq_idle", xip_wrq, 1'b0);
        @(posedge clk); #1;
        xip_ren = 1'b1;
        @(negedge clk);
        check_vec("rst_wrq_ren", xip_wrq, 1'b1);
        @(posedge clk); #1;
        xip_ren = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // Quad miss with dummy phase
        lg.delete();
        bus_read(24'h000104, rdt, err, waits);
        check_vec("miss_rdt", rdt, 32'h33221100);
        check_vec("miss_err", err, 1'b0);
        check_vec("miss_waits", waits, 9);
        check_vec("miss_nbeats", lg.size(), 7);
        check_vec("opc_ctl", lg[0][43:32], 12'h087);
        check_vec("opc_dat", lg[0][31:0], 32'h6b000000);
        check_vec("adr_ctl", lg[1][43:32], 12'h497);
        check_vec("adr_dat", lg[1][31:0], 32'h00010000);
        check_vec("dmy_ctl", lg[2][43:32], 12'h407);
        check_vec("dat0_ctl", lg[3][43:32], 12'h51F);
        check_vec("dat2_ctl", lg[5][43:32], 12'h51F);
        check_vec("dat3_ctl", lg[6][43:32], 12'hD1F);

        // Hits on the buffered line
        lg.delete();
        bus_read(24'h000100, rdt, err, waits);
        check_vec("hit0_rdt", rdt, 32'hA3A2A1A0);
        check_vec("hit0_waits", waits, 0);
        bus_read(24'h000108, rdt, err, waits);
        check_vec("hit2_rdt", rdt, 32'hC3C2C1C0);
        check_vec("hit2_waits", waits, 0);
        bus_read(24'h00010C, rdt, err, waits);
        check_vec("hit3_rdt", rdt, 32'hD3D2D1D0);
        check_vec("hit3_waits", waits, 0);
        check_vec("hit_no_cmo", lg.size(), 0);

        // Write is refused immediately
        xip_wen = 1'b1; xip_adr = 24'h001234; xip_wdt = 32'h55;
        @(negedge clk);
        check_vec("wr_wrq", xip_wrq, 1'b0);
        check_vec("wr_err", xip_err, 1'b1);
        check_vec("wr_rdt", xip_rdt, 32'h0);
        @(posedge clk); #1;
        xip_wen = 1'b0;
        @(posedge clk); #1;
        check_vec("wr_no_cmo", lg.size(), 0);

        // No dummy phase; wrapping offset; 32-bit flash address on the twin
        cfg_dmy = 4'd0; adr_rof = 32'hFFFF_FFFC;
        lg.delete(); lg32.delete();
        bus_read(24'h000014, rdt, err, waits);
        check_vec("nodmy_rdt", rdt, 32'hA3A2A1A0);
        check_vec("nodmy_waits", waits, 8);
        check_vec("nodmy_nbeats", lg.size(), 6);
        check_vec("nodmy_adr_dat", lg[1][31:0], 32'h00001000);
        check_vec("nodmy_beat2", lg[2][43:32], 12'h51F);
        check_vec("a32_adr_ctl", lg32[1][43:32], 12'h49F);
        check_vec("a32_adr_dat", lg32[1][31:0], 32'h00000010);
        check_vec("a32_nbeats", lg32.size(), 6);

        // Error flag on a data beat
        cfg_dmy = 4'd8; adr_rof = '0; err_beat = 2;
        bus_read(24'h000204, rdt, err, waits);
        check_vec("err_flag", err, 1'b1);
        check_vec("err_rdt", rdt, 32'h0);
        err_beat = -1;
        bus_read(24'h000204, rdt, err, waits);
        check_vec("err_refetch_waits", waits, 9);
        check_vec("err_refetch_rdt", rdt, 32'h33221100);

        // Backpressure during the address beat
        xip_ren = 1'b1; xip_adr = 24'h000300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cmo_rdy = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_vec("stall_beat", {cmo_vld, cmo_ctl, cmo_dat}, {1'b1, 12'h497, 32'h00030000});
            @(posedge clk); #1;
        end
        cmo_rdy = 1'b1;
        wait_rsp(rdt, err, waits);
        check_vec("stall_rdt", rdt, 32'hA3A2A1A0);

        // Reset in the middle of the data phase
        xip_ren = 1'b1; xip_adr = 24'h000400; found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (cmo_vld && cmo_ctl[8:7] == 2'd2) found = 1;
            @(posedge clk); #1;
        end
        check_vec("dat_reached", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_vec("rst_mid_vld", cmo_vld, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; xip_ren = 1'b0;
        @(negedge clk);
        check_vec("rst_after_vld", cmo_vld, 1'b0);
        @(posedge clk); #1;
        bus_read(24'h000404, rdt, err, waits);
        check_vec("rst_refetch_waits", waits, 9);
        check_vec("rst_refetch_rdt", rdt, 32'h33221100);

        // Invalidate pulse
        bus_read(24'h000404, rdt, err, waits);
        check_vec("pre_inv_waits", waits, 0);
        cfg_inv = 1'b1;
        @(posedge clk); #1;
        cfg_inv = 1'b0;
        bus_read(24'h000404, rdt, err, waits);
        check_vec("inv_waits", waits, 9);
        check_vec("inv_rdt", rdt, 32'h33221100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
